// File: rtl/ibus_responder_pkg.sv
// Shared types for the instruction-bus responder.
// common holds base scalar types; pipes holds the responder's FSM and response types.
package common;
  typedef logic [31:0] u32;
endpackage

package pipes;
  import common::*;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } ibus_state_t;

  typedef struct packed {
    u32   data;
    logic err;
  } ibus_resp_t;
endpackage

// File: rtl/ibus_responder_if.sv
// Fetch-side instruction bus: request and response valid/ready channels.
// master = fetch stage, slave = responder.
interface ibus_responder_if;
  import common::*;

  logic ireq_valid;
  u32   ireq_addr;
  logic ireq_ready;
  logic iresp_valid;
  u32   iresp_data;
  logic iresp_err;
  logic iresp_ready;

  modport master (
    output ireq_valid,
    output ireq_addr,
    output iresp_ready,
    input  ireq_ready,
    input  iresp_valid,
    input  iresp_data,
    input  iresp_err
  );

  modport slave (
    input  ireq_valid,
    input  ireq_addr,
    input  iresp_ready,
    output ireq_ready,
    output iresp_valid,
    output iresp_data,
    output iresp_err
  );
endinterface

// File: rtl/ibus_responder_imem.sv
// Instruction word storage: one synchronous write port, one async read port.
// Contents are deliberately not reset.
module imem_array
  import common::*;
#(
  parameter int MEM_WORDS = 1024,
  localparam int AW = $clog2(MEM_WORDS)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  u32            wdata,
  input  logic [AW-1:0] raddr,
  output u32            rdata
);

  u32 mem_q [MEM_WORDS];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/ibus_responder.sv
// Fixed-latency instruction fetch responder with flush and held response.
// Data is read at accept; later loads never disturb an in-flight word.
module ibus_responder
  import common::*, pipes::*;
#(
  parameter int MEM_WORDS = 1024,
  parameter int LATENCY   = 2,
  parameter u32 BASE_ADDR = 32'h0000_0000,
  localparam int AW = $clog2(MEM_WORDS)
) (
  input  logic          clk,
  input  logic          reset,
  ibus_responder_if.slave bus,
  input  logic          flush,
  input  logic          load_en,
  input  logic [AW-1:0] load_addr,
  input  u32            load_data
);

  ibus_state_t state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  ibus_resp_t  resp_q, resp_d;

  u32            off;
  logic [AW-1:0] idx;
  logic          addr_err;
  u32            rdata;
  logic          ready;
  logic          accept;

  imem_array #(
    .MEM_WORDS(MEM_WORDS)
  ) u_mem (
    .clk  (clk),
    .we   (load_en),
    .waddr(load_addr),
    .wdata(load_data),
    .raddr(idx),
    .rdata(rdata)
  );

  // Wrap-around subtraction: addresses below BASE_ADDR land out of range.
  assign off      = bus.ireq_addr - BASE_ADDR;
  assign idx      = off[AW+1:2];
  assign addr_err = (|bus.ireq_addr[1:0])
                  | (|off[1:0])
                  | (|off[31:AW+2]);

  assign ready = reset && !flush
              && ((state_q == IDLE)
               || (state_q == RESP && bus.iresp_ready));
  assign accept = bus.ireq_valid && ready;

  assign bus.ireq_ready  = ready;
  assign bus.iresp_valid = (state_q == RESP);
  assign bus.iresp_data  = resp_q.data;
  assign bus.iresp_err   = resp_q.err;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    resp_d  = resp_q;
    unique case (state_q)
      IDLE: ;
      WAIT: begin
        if (cnt_q == 4'd1) begin
          state_d = RESP;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        if (bus.iresp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (accept) begin
      resp_d.err  = addr_err;
      resp_d.data = addr_err ? 32'h0 : rdata;
      if (LATENCY == 1) begin
        state_d = RESP;
        cnt_d   = 4'd0;
      end else begin
        state_d = WAIT;
        cnt_d   = 4'(LATENCY - 1);
      end
    end
    if (flush) begin
      state_d = IDLE;
      cnt_d   = 4'd0;
      resp_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      resp_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      resp_q  <= resp_d;
    end
  end

endmodule

// File: tb/tb_ibus_responder.sv
// Directed bench for ibus_responder: vector table plus corner sequences.
// Three instances cover LATENCY=2, a non-zero BASE_ADDR and LATENCY=1.
module tb_ibus_responder;
  import common::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;
  logic       fl0, le0, fl1, le1, fl2, le2;
  logic [9:0] la0, la1, la2;
  u32         ld0, ld1, ld2;

  ibus_responder_if b0 ();
  ibus_responder_if b1 ();
  ibus_responder_if b2 ();

  ibus_responder #(.LATENCY(2)) dut0 (
    .clk(clk), .reset(reset), .bus(b0),
    .flush(fl0), .load_en(le0),
    .load_addr(la0), .load_data(ld0)
  );

  ibus_responder #(
    .LATENCY(2), .BASE_ADDR(32'hBFC0_0000)
  ) dut1 (
    .clk(clk), .reset(reset), .bus(b1),
    .flush(fl1), .load_en(le1),
    .load_addr(la1), .load_data(ld1)
  );

  ibus_responder #(.LATENCY(1)) dut2 (
    .clk(clk), .reset(reset), .bus(b2),
    .flush(fl2), .load_en(le2),
    .load_addr(la2), .load_data(ld2)
  );

  typedef struct {
    logic       v;
    u32         addr;
    logic       rr;
    logic       fl;
    logic       le;
    logic [9:0] la;
    u32         ld;
    logic       ev;
    u32         ed;
    logic       ee;
    logic       er;
  } vec_t;

  vec_t tbl[$];
  int   total = 0;
  int   passed = 0;

  function automatic void add(
    logic v, u32 addr, logic rr, logic fl,
    logic le, logic [9:0] la, u32 ld,
    logic ev, u32 ed, logic ee, logic er);
    vec_t t;
    t.v = v; t.addr = addr; t.rr = rr; t.fl = fl;
    t.le = le; t.la = la; t.ld = ld;
    t.ev = ev; t.ed = ed; t.ee = ee; t.er = er;
    tbl.push_back(t);
  endfunction

  task automatic chk(input string name, input u32 got,
                     input u32 exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %h expected %h",
                  name, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  u32 w2 [4];

  initial begin
    reset = 1'b0;
    b0.ireq_valid = 0; b0.ireq_addr = 0; b0.iresp_ready = 0;
    b1.ireq_valid = 0; b1.ireq_addr = 0; b1.iresp_ready = 0;
    b2.ireq_valid = 0; b2.ireq_addr = 0; b2.iresp_ready = 0;
    fl0 = 0; le0 = 0; la0 = 0; ld0 = 0;
    fl1 = 0; le1 = 0; la1 = 0; ld1 = 0;
    fl2 = 0; le2 = 0; la2 = 0; ld2 = 0;
    step();
    b0.ireq_valid = 1'b1;
    step();
    chk("rst ready", 32'(b0.ireq_ready), 0);
    chk("rst valid", 32'(b0.iresp_valid), 0);
    chk("rst data", b0.iresp_data, 0);
    chk("rst err", 32'(b0.iresp_err), 0);
    b0.ireq_valid = 1'b0;
    reset = 1'b1;

    // preload dut0
    le0 = 1;
    la0 = 0;  ld0 = 32'h2008_0005; step();
    la0 = 1;  ld0 = 32'h1111_1111; step();
    la0 = 2;  ld0 = 32'h2222_2222; step();
    la0 = 3;  ld0 = 32'h0000_0000; step();
    la0 = 16; ld0 = 32'h1600_0016; step();
    le0 = 0;

    //  v  addr   rr fl le la  ld            ev ed            ee er
    add(1, 32'h0,  1, 0, 0, 0, 0,            0, 0,            0, 1);
    add(0, 32'h0,  1, 0, 0, 0, 0,            0, 0,            0, 0);
    add(0, 32'h0,  1, 0, 0, 0, 0,            1, 32'h20080005, 0, 1);
    add(0, 32'h0,  1, 0, 0, 0, 0,            0, 0,            0, 1);
    add(1, 32'h0,  0, 0, 0, 0, 0,            0, 0,            0, 1);
    add(0, 32'h0,  0, 0, 0, 0, 0,            0, 0,            0, 0);
    add(1, 32'h4,  0, 0, 0, 0, 0,            1, 32'h20080005, 0, 0);
    add(1, 32'h4,  0, 0, 0, 0, 0,            1, 32'h20080005, 0, 0);
    add(1, 32'h4,  0, 0, 0, 0, 0,            1, 32'h20080005, 0, 0);
    add(1, 32'h4,  1, 0, 0, 0, 0,            1, 32'h20080005, 0, 1);
    add(0, 32'h0,  1, 0, 0, 0, 0,            0, 0,            0, 0);
    add(0, 32'h0,  1, 0, 0, 0, 0,            1, 32'h11111111, 0, 1);
    add(1, 32'h2,  1, 0, 0, 0, 0,            0, 0,            0, 1);
    add(0, 32'h0,  1, 0, 0, 0, 0,            0, 0,            0, 0);
    add(1, 32'h1000, 1, 0, 0, 0, 0,          1, 0,            1, 1);
    add(0, 32'h0,  1, 0, 0, 0, 0,            0, 0,            0, 0);
    add(0, 32'h0,  1, 0, 0, 0, 0,            1, 0,            1, 1);
    add(1, 32'h8,  1, 0, 0, 0, 0,            0, 0,            0, 1);
    add(0, 32'h0,  1, 1, 0, 0, 0,            0, 0,            0, 0);
    add(0, 32'h0,  1, 0, 0, 0, 0,            0, 0,            0, 1);
    add(0, 32'h0,  1, 0, 0, 0, 0,            0, 0,            0, 1);
    add(1, 32'h40, 1, 0, 0, 0, 0,            0, 0,            0, 1);
    add(0, 32'h0,  1, 0, 1, 16, 32'h5555,    0, 0,            0, 0);
    add(0, 32'h0,  1, 0, 0, 0, 0,            1, 32'h16000016, 0, 1);
    add(1, 32'hC,  1, 0, 1, 3, 32'hDEADBEEF, 0, 0,            0, 1);
    add(0, 32'h0,  1, 0, 0, 0, 0,            0, 0,            0, 0);
    add(0, 32'h0,  1, 0, 0, 0, 0,            1, 32'h0,        0, 1);
    add(1, 32'hC,  1, 0, 0, 0, 0,            0, 0,            0, 1);
    add(0, 32'h0,  1, 0, 0, 0, 0,            0, 0,            0, 0);
    add(0, 32'h0,  0, 0, 0, 0, 0,            1, 32'hDEADBEEF, 0, 0);
    add(1, 32'h0,  1, 1, 0, 0, 0,            1, 32'hDEADBEEF, 0, 0);
    add(0, 32'h0,  1, 0, 0, 0, 0,            0, 0,            0, 1);
    add(0, 32'h0,  1, 0, 0, 0, 0,            0, 0,            0, 1);

    foreach (tbl[i]) begin
      b0.ireq_valid  = tbl[i].v;
      b0.ireq_addr   = tbl[i].addr;
      b0.iresp_ready = tbl[i].rr;
      fl0 = tbl[i].fl;
      le0 = tbl[i].le;
      la0 = tbl[i].la;
      ld0 = tbl[i].ld;
      #1;
      chk($sformatf("r%0d valid", i),
          32'(b0.iresp_valid), 32'(tbl[i].ev));
      chk($sformatf("r%0d ready", i),
          32'(b0.ireq_ready), 32'(tbl[i].er));
      if (tbl[i].ev) begin
        chk($sformatf("r%0d data", i),
            b0.iresp_data, tbl[i].ed);
        chk($sformatf("r%0d err", i),
            32'(b0.iresp_err), 32'(tbl[i].ee));
      end
      step();
    end
    b0.ireq_valid = 0; fl0 = 0; le0 = 0;

    // reset while a response is held
    b0.ireq_valid = 1; b0.ireq_addr = 0; b0.iresp_ready = 0;
    step();
    b0.ireq_valid = 0;
    step();
    chk("pre-rst valid", 32'(b0.iresp_valid), 1);
    chk("pre-rst data", b0.iresp_data, 32'h20080005);
    reset = 1'b0;
    b0.ireq_valid = 1;
    step();
    chk("mid-rst valid", 32'(b0.iresp_valid), 0);
    chk("mid-rst data", b0.iresp_data, 0);
    chk("mid-rst ready", 32'(b0.ireq_ready), 0);
    reset = 1'b1;
    b0.ireq_valid = 0;
    step();
    chk("post-rst valid", 32'(b0.iresp_valid), 0);

    // non-zero BASE_ADDR: address 0 wraps out of range
    le1 = 1; la1 = 0; ld1 = 32'hABCD_0001;
    step();
    le1 = 0;
    b1.ireq_valid = 1; b1.ireq_addr = 0; b1.iresp_ready = 1;
    #1;
    chk("base acc ready", 32'(b1.ireq_ready), 1);
    step();
    b1.ireq_valid = 0;
    step();
    b1.ireq_valid = 1; b1.ireq_addr = 32'hBFC0_0000;
    #1;
    chk("wrap valid", 32'(b1.iresp_valid), 1);
    chk("wrap err", 32'(b1.iresp_err), 1);
    chk("wrap data", b1.iresp_data, 0);
    step();
    b1.ireq_valid = 0;
    step();
    chk("base valid", 32'(b1.iresp_valid), 1);
    chk("base err", 32'(b1.iresp_err), 0);
    chk("base data", b1.iresp_data, 32'hABCD_0001);
    step();

    // LATENCY=1 back-to-back stream
    le2 = 1;
    for (int k = 0; k < 4; k++) begin
      w2[k] = 32'hA000_0000 + 32'(k * 17 + 3);
      la2 = 10'(k); ld2 = w2[k];
      step();
    end
    le2 = 0;
    b2.iresp_ready = 1;
    for (int k = 0; k < 5; k++) begin
      b2.ireq_valid = (k < 4);
      b2.ireq_addr  = 32'(k * 4);
      #1;
      chk($sformatf("l1 c%0d valid", k),
          32'(b2.iresp_valid), 32'(k > 0));
      chk($sformatf("l1 c%0d ready", k),
          32'(b2.ireq_ready), 1);
      if (k > 0) begin
        chk($sformatf("l1 c%0d data", k),
            b2.iresp_data, w2[k-1]);
      end
      step();
    end
    b2.ireq_valid = 0;
    #1;
    chk("l1 drain valid", 32'(b2.iresp_valid), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
